// File: rtl/xor_descrambler_4bit_if.sv
// Stream interface for xor_descrambler_4bit: input word channel and output word channel.
// Optional parity signals in_par/par_err exist only when DESCR_PARITY_EN is defined.
interface xor_descrambler_4bit_if;
  localparam int unsigned DATA_W = 4;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef DESCR_PARITY_EN
  logic              in_par;
  logic              par_err;
`endif

`ifdef DESCR_PARITY_EN
  // Producer/consumer side of the descrambler
  modport master (
    output in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, par_err
  );

  // Descrambler side
  modport slave (
    input  in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, par_err
  );
`else
  // Producer/consumer side of the descrambler
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Descrambler side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/xor_descrambler_4bit.sv
// 4-bit additive descrambler: XORs each accepted word with 4 keystream bits from a
// 7-bit LFSR (x^7+x^6+1), one-entry output register with full-throughput handshake.
// Optional macro DESCR_PARITY_EN adds even-parity checking of the scrambled word.
module xor_descrambler_4bit #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync,
  xor_descrambler_4bit_if.slave bus,
  output logic [7:0]           word_cnt
);

  localparam int unsigned DATA_W = 4;
  localparam int unsigned LFSR_W = 7;
  localparam int unsigned CNT_W  = 8;

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_adv;
  logic [DATA_W-1:0] w_key;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              w_in_ready;
  logic              w_accept;

  // Ready whenever the output slot is empty or is being drained this cycle
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign word_cnt      = r_word_cnt;

  // Four LFSR steps per word; key[0] is the feedback bit of the first step
  always_comb begin
    w_key      = '0;
    w_lfsr_adv = r_lfsr;
    for (int i = 0; i < int'(DATA_W); i++) begin
      w_key[i]   = w_lfsr_adv[6] ^ w_lfsr_adv[5];
      w_lfsr_adv = {w_lfsr_adv[5:0], w_key[i]};
    end
  end

  // Output register: load on accept, drop valid on drain, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data ^ w_key;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Keystream state and word counter; sync reloads the seed and wins over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr     <= SEED;
      r_word_cnt <= '0;
    end else if (sync) begin
      r_lfsr     <= SEED;
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_lfsr     <= w_lfsr_adv;
      r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

`ifdef DESCR_PARITY_EN
  logic r_par_err;

  // Parity flag travels with the word it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (w_accept) begin
      r_par_err <= (^bus.in_data) ^ bus.in_par;
    end
  end

  assign bus.par_err = r_par_err;
`endif

endmodule
